// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM status types, plus the memory arbiter state encoding.
// The arbiter's fairness default lives here so the wrapper and the block agree on it.
package cpu_types_pkg;
    localparam int WORD_BITS = 32;
    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} memarb_state_t;

    localparam int FAIR_LIMIT_DEF = 4;
endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access; data wins by default.
// Define MEM_ARB_FAIR_EN to let a pending fetch in after FAIR_LIMIT consecutive data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ramerr
);

    memarb_state_t state, next_state;
    ramstate_t     rs;
    logic          err_hit;
    logic          fair_pick_i;

    assign rs = ramstate_t'(ramstate);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            ramerr <= 1'b0;
        end else begin
            state <= next_state;
            if (err_hit) ramerr <= 1'b1;
        end
    end

    // Every grant ends in IDLE: the requester's enable is stale at its completing edge.
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        err_hit    = 1'b0;
        case (state)
            IDLE: begin
                if ((dREN || dWEN) && !fair_pick_i) next_state = GRANT_D;
                else if (iREN)                      next_state = GRANT_I;
            end
            GRANT_D: begin
                if (dREN || dWEN) begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (rs == ACCESS) begin
                        dwait = 1'b0;
                        if (!dWEN) dload = ramload;
                    end
                    err_hit = (rs == ERROR);
                    if (rs == ACCESS || rs == ERROR) next_state = IDLE;
                end else begin
                    next_state = IDLE;
                end
            end
            GRANT_I: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (rs == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                    err_hit = (rs == ERROR);
                    if (rs == ACCESS || rs == ERROR) next_state = IDLE;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef MEM_ARB_FAIR_EN
    logic [2:0] fair_cnt;

    // Counts data completions that happened while a fetch was waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fair_cnt <= 3'd0;
        end else if (!iwait || (!dwait && !iREN)) begin
            fair_cnt <= 3'd0;
        end else if (!dwait && fair_cnt != 3'd7) begin
            fair_cnt <= fair_cnt + 3'd1;
        end
    end

    assign fair_pick_i = iREN && (int'(fair_cnt) >= FAIR_LIMIT);
`else
    assign fair_pick_i = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data requester coming out of the caches block.
- Generates the iwait/dwait handshakes that caches turns into ihit/dhit.
- Data requests have priority over instruction requests.
- An optional fairness counter stops a run of data accesses from starving fetch.
- Sits between caches and the RAM model, inside memory control; the wrapper binds these flat ports to the cache_control_if signals.

Parameters:
- WORD_W, 32, width of addresses and data words.
- FAIR_LIMIT, 4, number of consecutive data grants allowed while a fetch is pending (used only with MEM_ARB_FAIR_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset; asynchronous assert, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  WORD_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  data write value.
- iwait  out  1  1 = instruction access not complete this cycle.
- dwait  out  1  1 = data access not complete this cycle.
- iload  out  WORD_W  fetched instruction; valid when iwait=0.
- dload  out  WORD_W  loaded data; valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status, ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramerr  out  1  sticky: an ERROR was seen during a grant.

Behaviour:
- Reset (nRST=0, async): state=IDLE, fair count=0, ramerr=0.
  - Outputs during and after reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - All ram enables low; both waits high.
  - On a clock edge: if dREN|dWEN, go to GRANT_D; else if iREN, go to GRANT_I; else stay IDLE.
  - No access completes in IDLE, so minimum latency is 2 cycles: request cycle, then grant cycle with ACCESS.
- GRANT_D:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore (write wins when both dREN and dWEN are set).
  - Else: ramREN=1, ramstore=0.
  - iwait stays 1.
- GRANT_I: ramREN=1, ramaddr=iaddr; dwait stays 1.
- Completion:
  - While granted and ramstate==ACCESS, the granted wait is 0 combinationally in that same cycle.
  - The matching load output equals ramload (dload is 0 for a write).
  - Next state is IDLE. Always return to IDLE: the requester's request is stale at the completing edge, so it must not be re-granted.
- Waiting: ramstate FREE or BUSY while granted means hold the grant with ram outputs stable and wait=1.
- ERROR while granted:
  - Wait stays 1; ramerr is set and stays set until reset.
  - Next state is IDLE; the request is re-arbitrated normally.
- Abort:
  - If the granted requester drops its enable(s) before ACCESS, ram enables go low in that same cycle (they are combinational from the inputs).
  - Next state is IDLE; no wait is deasserted.
- Requester change mid-grant: a new request from the other side is ignored until the FSM returns to IDLE.
- Load outputs are 0 whenever the corresponding wait is 1.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - A 3-bit saturating fair count increments on each completed data grant while iREN=1.
  - It clears on each completed instruction grant, and also whenever iREN=0 at a data completion.
  - In IDLE, if count>=FAIR_LIMIT and iREN=1, GRANT_I is chosen even when a data request is present.
- Undefined: strict data priority; no counter logic is synthesized.

Decomposition:
- cpu_types_pkg (existing) supplies word_t and ramstate_t.
- Add to cpu_types_pkg: memarb_state_t enum (IDLE, GRANT_I, GRANT_D) and FAIR_LIMIT_DEF=4.
- No sub-module: the FSM, output mux and counter fit in a single module.

Test Plan:
- Reset mid-grant: assert nRST=0 during GRANT_D with ramWEN=1 -> ramWEN=0 and both waits=1 immediately; state is IDLE after release.
- Single fetch: iREN=1, iaddr=0x40, RAM gives ACCESS on the 2nd grant cycle with ramload=0x8C220004 -> ramREN=1, ramaddr=0x40; iwait=0 for exactly 1 cycle with iload=0x8C220004; then IDLE.
- Simultaneous requests: iREN=1, dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramstate=ACCESS immediately -> data write granted first (ramWEN=1, ramstore=0xDEADBEEF, dwait=0); after an IDLE cycle GRANT_I, then iwait=0.
- Abort: dREN=1 granted, ramstate=BUSY, dREN dropped the next cycle -> ramREN=0 in that cycle; dwait stays 1; next state IDLE.
- Error: ramstate=ERROR during GRANT_I -> iwait stays 1, ramerr=1 and stays 1 through later successful accesses.
- Fairness (MEM_ARB_FAIR_EN defined): iREN=1 held with continuous dREN, 1-cycle ACCESS -> exactly 4 data completions, then one instruction completion, repeating. Without the macro -> iwait never drops.
